// File: rtl/bitscan_priority_encoder.sv
// ---------------------------------------------------------------------------
// bitscan_priority_encoder
//
// Captures a request word and emits the index of every set bit, one beat per
// set bit, over a valid/ready output handshake. Default order is fixed
// MSB-first. Defining the macro PENC_ROUND_ROBIN_EN switches to a rotating
// scan: a pointer remembers where the last beat left off and each scan runs
// downward from it, wrapping from 0 to WIDTH-1.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   D         : request vector (WIDTH bits)
//   in_valid  : D is valid this cycle
//   in_ready  : block accepts D this cycle (high only while idle)
//   y         : index of the set bit presented on this beat
//   out_valid : y / zero / last / num_set are valid
//   out_ready : consumer accepts the current beat
//   zero      : captured word had no bits set (single beat, y = 0)
//   last      : final beat for the captured word
//   num_set   : population count of the captured word
// ---------------------------------------------------------------------------
module bitscan_priority_encoder #(
   parameter int  WIDTH = 8,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             zero,
   output logic             last,
   output logic [IDX_W:0]   num_set
);

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] pend_clr;
   logic [IDX_W-1:0] y_acc;
   logic [IDX_W-1:0] y_nxt;

   function automatic logic [IDX_W:0] pop_count(input logic [WIDTH-1:0] v);
      logic [IDX_W:0]   c;
      logic [IDX_W-1:0] k;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         k = IDX_W'(i);
         c = c + (IDX_W+1)'(v[k]);
      end
      return c;
   endfunction

   // Clearing the lowest set bit leaves nothing when at most one bit is set.
   function automatic logic at_most_one(input logic [WIDTH-1:0] v);
      return (v & (v - WIDTH'(1))) == '0;
   endfunction

`ifdef PENC_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_adv;

   // First set bit found scanning downward from start, wrapping 0 -> WIDTH-1.
   function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v,
                                             input logic [IDX_W-1:0] start);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] k;
      logic             found;
      int               j;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         j = int'(start) - i;
         if (j < 0) j = j + WIDTH;
         k = IDX_W'(j);
         if (!found && v[k]) begin
            idx   = k;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   always_comb begin
      // Pointer value after the current beat completes: one below y, wrapped.
      ptr_adv  = (y == '0) ? IDX_W'(WIDTH-1) : y - IDX_W'(1);
      pend_clr = pend & ~(WIDTH'(1) << y);
      y_acc    = pick(D, ptr);
      y_nxt    = pick(pend_clr, ptr_adv);
   end
`else
   // Highest set bit; later (higher) indices overwrite earlier ones.
   function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] k;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         k = IDX_W'(i);
         if (v[k]) idx = k;
      end
      return idx;
   endfunction

   always_comb begin
      pend_clr = pend & ~(WIDTH'(1) << y);
      y_acc    = pick(D);
      y_nxt    = pick(pend_clr);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         y         <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b0;
         last      <= 1'b0;
         num_set   <= '0;
`ifdef PENC_ROUND_ROBIN_EN
         ptr       <= IDX_W'(WIDTH-1);
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pend      <= D;
                  y         <= y_acc;
                  zero      <= (D == '0);
                  last      <= at_most_one(D);
                  num_set   <= pop_count(D);
                  out_valid <= 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               // Without out_ready every output register simply holds.
               if (out_ready) begin
`ifdef PENC_ROUND_ROBIN_EN
                  if (!zero) ptr <= ptr_adv;
`endif
                  pend <= pend_clr;
                  if (last) begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     y    <= y_nxt;
                     last <= at_most_one(pend_clr);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);

endmodule

// File: doc/bitscan_priority_encoder.md
BITSCAN_PRIORITY_ENCODER -- requirements
Module: bitscan_priority_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of request bits (legal range 2..256).
REQ-002 The block SHALL have derived localparam IDX_W = $clog2(WIDTH), the index width.
REQ-003 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port D, input, WIDTH: the request vector.
REQ-006 Port in_valid, input, 1: D is valid this cycle.
REQ-007 Port in_ready, output, 1: the block accepts D this cycle.
REQ-008 Port y, output, IDX_W: the encoded index of the current set bit.
REQ-009 Port out_valid, output, 1: y, zero, last and num_set are valid.
REQ-010 Port out_ready, input, 1: the consumer accepts the current output beat.
REQ-011 Port zero, output, 1: the captured word had no bits set.
REQ-012 Port last, output, 1: this is the final beat for the captured word.
REQ-013 Port num_set, output, IDX_W+1: the population count of the captured word, constant across all of its beats.

Function
REQ-014 The block SHALL implement an FSM with two states. In IDLE, in_ready=1 and out_valid=0. In DRAIN, in_ready=0 and out_valid=1.
REQ-015 An accept occurs when in_valid&&in_ready; on an accept the block SHALL capture D into register pend, compute num_set, and go to DRAIN, so that out_valid rises exactly 1 cycle after the accept.
REQ-016 In DRAIN, y SHALL equal the highest-priority set bit of pend. The fixed priority order is MSB first (D[WIDTH-1] highest).
REQ-017 Beat handshake: a beat completes on out_valid&&out_ready; the block SHALL then clear pend[y] and present the next index on the following cycle.
REQ-018 last SHALL be 1 when pend has at most one bit set. Completing a beat with last=1 SHALL return the FSM to IDLE.
REQ-019 Captured word 0: the block SHALL emit exactly one beat with zero=1, y=0, last=1 and num_set=0.
REQ-020 Captured word with all bits set: the block SHALL emit WIDTH beats, and num_set SHALL equal WIDTH (which needs the IDX_W+1 width).
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL be held stable.
REQ-022 Throughput: a word with k set bits SHALL occupy max(k,1)+1 cycles when out_ready is held at 1. D is ignored while in DRAIN.
REQ-023 Outputs SHALL be registered, with no combinational path from D or in_valid to any output.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set state to IDLE, pend=0, y=0, out_valid=0, zero=0, last=0, num_set=0 and the rotation pointer to WIDTH-1.
REQ-025 Reset asserted mid-DRAIN SHALL abandon the remaining beats. out_valid=0 and in_ready=1 SHALL hold on the cycle after rst deasserts.
REQ-026 An in_valid presented on a reset cycle SHALL not be accepted.

Configuration
REQ-027 When macro PENC_ROUND_ROBIN_EN is defined, the block SHALL keep a pointer ptr (IDX_W bits).
REQ-028 With PENC_ROUND_ROBIN_EN defined, each new word SHALL be scanned in descending order starting at ptr and wrapping from 0 to WIDTH-1.
REQ-029 With PENC_ROUND_ROBIN_EN defined, after each completed beat with zero=0, ptr SHALL be set to (y-1) mod WIDTH. Within a word the scan continues from that ptr.
REQ-030 When PENC_ROUND_ROBIN_EN is not defined, the block SHALL use the fixed MSB-first order of REQ-016 and SHALL contain no ptr register.

Verification
REQ-031 WIDTH=8, D=8'b1010_0100, out_ready=1 -> y=7,5,2 on three consecutive cycles, last=1 only on y=2, num_set=3, in_ready=1 on the next cycle.
REQ-032 D=8'h00 -> one beat with zero=1, y=0, last=1, num_set=0, then IDLE.
REQ-033 D=8'h81 with out_ready=0 for 3 cycles -> y=7 held stable with out_valid=1 for 3 cycles; after out_ready=1, beats y=7 then y=0.
REQ-034 D=8'hFF, rst pulsed after the second beat -> out_valid=0 on the cycle after reset; a new D=8'h02 then yields a single beat y=1.
REQ-035 D=8'hFF -> 8 beats y=7..0, num_set=8, last only on y=0.
REQ-036 PENC_ROUND_ROBIN_EN defined: D=8'h10 then D=8'h84 -> beats y=4, then y=2, y=7. Without the macro, the second word gives y=7, y=2.
